// File: rtl/pulse_train_gen_if.sv
// Control and status bundle for pulse_train_gen: trigger/config inputs and pulse outputs.
interface pulse_train_gen_if #(
  parameter int WIDTH = 25,
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic                   enable;
  logic                   abort;
  logic                   tim;
  logic [1:0]             mode;
  logic [CNT_W-1:0]       burst_n;
  logic [WIDTH-1:0]       frame_in;
  logic [NCH*WIDTH-1:0]   delay_in;
  logic [NCH*WIDTH-1:0]   width_in;
  logic [NCH-1:0]         ch_en;
  logic [NCH-1:0]         out_pulse;
  logic                   frame_strobe;
  logic                   busy;
  logic                   done;

  modport master (
    output enable, abort, tim, mode, burst_n, frame_in, delay_in, width_in, ch_en,
    input  out_pulse, frame_strobe, busy, done
  );

  modport slave (
    input  enable, abort, tim, mode, burst_n, frame_in, delay_in, width_in, ch_en,
    output out_pulse, frame_strobe, busy, done
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Multi-channel, multi-frame pulse train generator. A start trigger launches
// single-shot, burst or continuous frames; each enabled channel emits one pulse
// per frame at its own delay/width. Time spent with tim high before the start
// shortens the first frame so the train ends aligned to the ADC strobe.
module pulse_train_gen #(
  parameter int WIDTH = 25,
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  pulse_train_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [WIDTH-1:0]       r_tim_cnt;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_frames;
  logic [WIDTH-1:0]       r_len_cur;
  logic [WIDTH-1:0]       r_frame_len;
  logic [1:0]             r_mode;
  logic [CNT_W-1:0]       r_burst_n;
  logic [NCH*WIDTH-1:0]   r_delay;
  logic [NCH*WIDTH-1:0]   r_width;
  logic [NCH-1:0]         r_ch_en;

  logic [NCH-1:0]         r_out_pulse;
  logic                   r_frame_strobe;
  logic                   r_busy;
  logic                   r_done;

  logic [WIDTH-1:0]       w_len0;
  logic [WIDTH-1:0]       w_burst_eff;
  logic                   w_frame_end;
  logic                   w_last_frame;
  logic [NCH-1:0]         w_hit;
  logic [NCH-1:0]         w_pulse_nxt;
  logic                   w_strobe_nxt;

  // A frame length of zero is meaningless; treat it as a one-cycle frame.
  function automatic logic [WIDTH-1:0] force_nonzero(input logic [WIDTH-1:0] len);
    logic [WIDTH-1:0] res;
    if (len == {WIDTH{1'b0}}) begin
      res = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = len;
    end
    return res;
  endfunction

  assign w_burst_eff = force_nonzero(WIDTH'(r_burst_n));
  assign w_frame_end = (r_cnt == (r_len_cur - WIDTH'(1)));

  // First frame length: shortened by the tim alignment count when it fits.
  always_comb begin
    w_len0 = bus.frame_in;
    if (r_tim_cnt < bus.frame_in) begin
      w_len0 = force_nonzero(bus.frame_in - r_tim_cnt);
    end else begin
      w_len0 = force_nonzero(bus.frame_in);
    end
  end

  // Decide whether the frame now ending is the last one of the train.
  always_comb begin
    w_last_frame = 1'b1;
    case (r_mode)
      2'd1:    w_last_frame = ((r_frames + WIDTH'(1)) == w_burst_eff);
      2'd2:    w_last_frame = 1'b0;
      default: w_last_frame = 1'b1;
    endcase
  end

  // Per-channel window test; end bound uses one extra bit so it never wraps.
  always_comb begin
    w_hit = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      w_hit[i] = r_ch_en[i]
              && (r_cnt >= r_delay[i*WIDTH +: WIDTH])
              && ({1'b0, r_cnt} < ({1'b0, r_delay[i*WIDTH +: WIDTH]} + {1'b0, r_width[i*WIDTH +: WIDTH]}))
              && (r_cnt < r_len_cur);
    end
  end

  // Next-state and next-output logic of the train sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_pulse_nxt  = {NCH{1'b0}};
    w_strobe_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.tim) begin
          w_state_nxt = S_IDLE;
        end else if (bus.enable) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_strobe_nxt = w_frame_end;
          if (w_frame_end && w_last_frame) begin
            w_state_nxt = S_DONE;
            w_pulse_nxt = {NCH{1'b0}};
          end else begin
            w_state_nxt = S_RUN;
            w_pulse_nxt = w_hit;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tim_cnt      <= {WIDTH{1'b0}};
      r_cnt          <= {WIDTH{1'b0}};
      r_frames       <= {WIDTH{1'b0}};
      r_len_cur      <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_frame_len    <= {WIDTH{1'b0}};
      r_mode         <= 2'd0;
      r_burst_n      <= {CNT_W{1'b0}};
      r_delay        <= {(NCH*WIDTH){1'b0}};
      r_width        <= {(NCH*WIDTH){1'b0}};
      r_ch_en        <= {NCH{1'b0}};
      r_out_pulse    <= {NCH{1'b0}};
      r_frame_strobe <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_out_pulse    <= w_pulse_nxt;
      r_frame_strobe <= w_strobe_nxt;
      r_busy         <= (w_state_nxt == S_RUN);
      r_done         <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.tim) begin
            if (r_tim_cnt != {WIDTH{1'b1}}) begin
              r_tim_cnt <= r_tim_cnt + WIDTH'(1);
            end
          end else if (bus.enable) begin
            r_mode      <= bus.mode;
            r_burst_n   <= bus.burst_n;
            r_frame_len <= bus.frame_in;
            r_delay     <= bus.delay_in;
            r_width     <= bus.width_in;
            r_ch_en     <= bus.ch_en;
            r_len_cur   <= w_len0;
            r_cnt       <= {WIDTH{1'b0}};
            r_frames    <= {WIDTH{1'b0}};
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_tim_cnt <= {WIDTH{1'b0}};
            r_cnt     <= {WIDTH{1'b0}};
          end else if (w_frame_end) begin
            r_cnt     <= {WIDTH{1'b0}};
            r_frames  <= r_frames + WIDTH'(1);
            r_len_cur <= force_nonzero(r_frame_len);
            if (w_last_frame) begin
              r_tim_cnt <= {WIDTH{1'b0}};
            end
          end else begin
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign bus.out_pulse    = r_out_pulse;
  assign bus.frame_strobe = r_frame_strobe;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: expected per-cycle output vectors are
// queued when a train is launched and popped/compared each cycle.
module tb_pulse_train_gen;
  localparam int WIDTH = 25;
  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam longint ONES = (longint'(1) << WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;

  pulse_train_gen_if #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) bus ();

  pulse_train_gen #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] p;
    logic           s;
    logic           b;
    logic           d;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  longint      e_delay[NCH];
  longint      e_width[NCH];
  logic [NCH-1:0] e_en;

  task automatic cfg(input logic [1:0] m, input int bn, input longint fr, input logic [NCH-1:0] en);
    bus.mode     = m;
    bus.burst_n  = CNT_W'(bn);
    bus.frame_in = WIDTH'(fr);
    bus.ch_en    = en;
    e_en         = en;
  endtask

  task automatic set_ch(input int ch, input longint d, input longint w);
    bus.delay_in[ch*WIDTH +: WIDTH] = WIDTH'(d);
    bus.width_in[ch*WIDTH +: WIDTH] = WIDTH'(w);
    e_delay[ch] = d;
    e_width[ch] = w;
  endtask

  function automatic logic [NCH-1:0] hits(input longint k, input longint lf);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      r[i] = e_en[i] && (k >= e_delay[i]) && (k < e_delay[i] + e_width[i]) && (k < lf);
    end
    return r;
  endfunction

  // Expected vectors for cycles c = 0 .. ncyc-1, c = 0 being the first RUN cycle.
  task automatic push_train(input longint l0, input longint l, input longint nfr,
                            input int ncyc, input int abort_at, input int reset_at);
    longint t_total;
    longint pos;
    longint lf;
    exp_t   e;
    t_total = l0 + (nfr - 1) * l;
    for (int c = 0; c < ncyc; c++) begin
      e = '0;
      if (!((abort_at >= 0 && c > abort_at) || (reset_at >= 0 && c > reset_at))) begin
        e.b = (c < t_total);
        e.d = (c == t_total);
        if (c >= 1 && (c - 1) < t_total) begin
          pos = c - 1;
          lf  = l0;
          while (pos >= lf) begin
            pos = pos - lf;
            lf  = l;
          end
          e.s = (pos == lf - 1);
          e.p = (c < t_total) ? hits(pos, lf) : '0;
        end
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic check_cycle(input string tag, input int c);
    exp_t e;
    exp_t obs;
    obs = exp_t'({bus.out_pulse, bus.frame_strobe, bus.busy, bus.done});
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s cyc=%0d scoreboard empty got=%b", tag, c, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s cyc=%0d got={p,s,b,d}=%b expected=%b", tag, c, obs, e);
      end
    end
  endtask

  task automatic idle_cycles(input string tag, input int n, input logic tim_v, input logic en_v);
    for (int c = 0; c < n; c++) begin
      bus.tim    = tim_v;
      bus.enable = en_v;
      sb_q.push_back('0);
      @(negedge clk);
      check_cycle(tag, c);
      @(posedge clk); #1;
    end
    bus.tim    = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic run_train(input string tag, input longint l0, input longint l, input longint nfr,
                           input int ncyc, input int abort_at, input int reset_at, input bit poke);
    logic [NCH*WIDTH-1:0] saved_delay;
    longint t_total;
    t_total     = l0 + (nfr - 1) * l;
    saved_delay = bus.delay_in;
    push_train(l0, l, nfr, ncyc, abort_at, reset_at);
    bus.tim    = 1'b0;
    bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      bus.abort = (c == abort_at);
      reset     = (c == reset_at);
      if (poke) begin
        if (c == 3) bus.delay_in = ~saved_delay;
        bus.enable = (c == 6) || (c == t_total);
      end
      @(negedge clk);
      check_cycle(tag, c);
      @(posedge clk); #1;
    end
    bus.abort    = 1'b0;
    reset        = 1'b0;
    bus.enable   = 1'b0;
    bus.delay_in = saved_delay;
  endtask

  task automatic base_channels();
    set_ch(0, 3, 4);
    set_ch(1, 10, 2);
    set_ch(2, 5, 3);
    set_ch(3, 0, 0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.abort    = 1'b0;
    bus.tim      = 1'b0;
    bus.delay_in = '0;
    bus.width_in = '0;
    cfg(2'd0, 0, 20, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back('0);
    @(negedge clk);
    check_cycle("reset", 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single shot; channel 2 configured but disabled.
    base_channels();
    cfg(2'd0, 0, 20, 4'b0011);
    run_train("single", 20, 20, 1, 23, -1, -1, 1'b0);

    // Burst of 3 frames, then burst_n = 0 treated as 1.
    cfg(2'd1, 3, 8, 4'b0011);
    run_train("burst3", 8, 8, 3, 27, -1, -1, 1'b0);
    cfg(2'd1, 0, 8, 4'b0011);
    run_train("burst0", 8, 8, 1, 11, -1, -1, 1'b0);

    // tim alignment: enable held together with tim must be ignored.
    cfg(2'd0, 0, 20, 4'b0011);
    idle_cycles("tim5", 5, 1'b1, 1'b1);
    run_train("tim5run", 15, 20, 1, 18, -1, -1, 1'b0);
    idle_cycles("tim25", 25, 1'b1, 1'b0);
    run_train("tim25run", 20, 20, 1, 23, -1, -1, 1'b0);

    // Boundaries: clipped window, zero width, delay at frame end, all-ones.
    set_ch(0, 6, 10);
    set_ch(1, 2, 0);
    set_ch(2, 8, 3);
    set_ch(3, ONES, ONES);
    cfg(2'd1, 2, 8, 4'b1111);
    run_train("bound", 8, 8, 2, 19, -1, -1, 1'b0);
    // Large width must not wrap the window end.
    set_ch(0, 4, ONES);
    set_ch(1, 0, 1);
    cfg(2'd0, 0, 8, 4'b0011);
    run_train("nowrap", 8, 8, 1, 11, -1, -1, 1'b0);

    // Continuous with abort, then a clean restart.
    base_channels();
    cfg(2'd2, 0, 10, 4'b0011);
    run_train("cont_abort", 10, 10, 1000, 41, 37, -1, 1'b0);
    cfg(2'd0, 0, 20, 4'b0011);
    run_train("restart", 20, 20, 1, 23, -1, -1, 1'b0);

    // Reset during an active pulse, then input changes during RUN/DONE.
    run_train("rst_mid", 20, 20, 1, 12, -1, 5, 1'b0);
    run_train("poke", 20, 20, 1, 23, -1, -1, 1'b1);
    idle_cycles("after", 3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
